alu_result_fifo: RTL and testbench

Buffers results leaving the 32-bit logic/ALU stage so that a slower consumer (writeback, display driver, UART dumper) can drain them at its own rate. Each accepted result is stored with its 2-bit op code and two derived flags (zero, negative). Entries are returned in arrival order. Upstream and downstream both use a valid/ready handshake.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/result_fifo_mem.sv | 31 +++
 rtl/alu_result_fifo.sv | 118 +++++++++++
 tb/tb_alu_result_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result buffering path.
//   ALU_OP_*         : op codes produced by the logic stage
//   ALU_DATA_W       : default result width
//   ALU_FIFO_DEPTH   : default result FIFO depth
//   result_entry_t   : one buffered result with its derived flags
package alu_pkg;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_XOR = 2'b10;
  localparam logic [1:0] ALU_OP_NOR = 2'b11;

  localparam int unsigned ALU_DATA_W     = 32;
  localparam int unsigned ALU_FIFO_DEPTH = 4;

  // Field order defines the packed layout used by the FIFO storage: {op, y, zero, neg}.
  typedef struct packed {
    logic [1:0]            op;
    logic [ALU_DATA_W-1:0] y;
    logic                  zero;
    logic                  neg;
  } result_entry_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for the result FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// The array is deliberately not reset; occupancy tracking lives in the parent.
module result_fifo_mem #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO between the logic/ALU stage and a slower consumer.
//   clk, reset          : clock and asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready = not full)
//   in_op, in_Y         : op code and result being pushed
//   out_valid/out_ready : downstream handshake (out_valid = not empty)
//   out_op, out_Y       : head entry, forced to 0 when empty
//   out_zero, out_neg   : flags captured when the head entry was pushed
//   count               : occupancy, 0..DEPTH
//   accepted            : wrapping count of pushes since reset
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DATA  = ALU_DATA_W,
  parameter int unsigned DEPTH = ALU_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [DATA-1:0]        in_Y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [DATA-1:0]        out_Y,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            accepted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA + 4;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   accepted_q, accepted_d;

  logic          full, empty, push, pop;
  logic [EW-1:0] wr_entry, rd_entry;

  // Ready/valid depend on registered occupancy only, so a full FIFO never accepts
  // in the same cycle it is popped.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  // Flags are frozen at push time; layout matches result_entry_t.
  assign wr_entry = {in_op, in_Y, (in_Y == '0), in_Y[DATA-1]};

  result_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      accepted_d = accepted_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
    end
  end

  // Memory is never cleared, so head data must be masked while empty.
  always_comb begin
    out_op   = '0;
    out_Y    = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (!empty) begin
      out_op   = rd_entry[EW-1 -: 2];
      out_Y    = rd_entry[DATA+1:2];
      out_zero = rd_entry[1];
      out_neg  = rd_entry[0];
    end
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;
  assign accepted  = accepted_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed stimulus, a queue-based
// reference model compared every negative clock edge, plus literal checks.
module tb_alu_result_fifo;

  localparam int unsigned DATA  = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [DATA-1:0]  in_Y;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_op;
  logic [DATA-1:0]  out_Y;
  logic             out_zero;
  logic             out_neg;
  logic [2:0]       count;
  logic [15:0]      accepted;

  int errors = 0;
  int checks = 0;

  alu_result_fifo #(
    .DATA  (DATA),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_Y      (in_Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_Y     (out_Y),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .count     (count),
    .accepted  (accepted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of (op, value) plus a push counter.
  typedef struct {
    logic [1:0]      op;
    logic [DATA-1:0] y;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_acc = 16'd0;
    end else begin
      int  n;
      bit  do_push, do_pop;
      n       = mq.size();
      do_push = in_valid && (n < DEPTH);
      do_pop  = out_ready && (n > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        ent_t e;
        e.op = in_op;
        e.y  = in_Y;
        mq.push_back(e);
        m_acc = m_acc + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic            ev;
      logic [1:0]      eop;
      logic [DATA-1:0] ey;
      ev  = (mq.size() > 0);
      eop = ev ? mq[0].op : 2'b00;
      ey  = ev ? mq[0].y : '0;
      chk("cmp_out_valid", 64'(out_valid), 64'(ev));
      chk("cmp_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("cmp_count", 64'(count), 64'(mq.size()));
      chk("cmp_out_op", 64'(out_op), 64'(eop));
      chk("cmp_out_Y", 64'(out_Y), 64'(ey));
      chk("cmp_out_zero", 64'(out_zero), 64'(ev && (ey == 0)));
      chk("cmp_out_neg", 64'(out_neg), 64'(ev && (ey >= 32'h8000_0000)));
      chk("cmp_accepted", 64'(accepted), 64'(m_acc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
    step();
  endtask

  task automatic push_one(input logic [1:0] op, input logic [DATA-1:0] y);
    in_valid = 1'b1;
    in_op    = op;
    in_Y     = y;
    step();
    in_valid = 1'b0;
  endtask

  logic [DATA-1:0] fill_v [4];
  logic            fill_n [4];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 2'b00;
    in_Y      = '0;
    fill_v[0] = 32'h0000_0001; fill_n[0] = 1'b0;
    fill_v[1] = 32'h8000_0000; fill_n[1] = 1'b1;
    fill_v[2] = 32'hFFFF_FFFF; fill_n[2] = 1'b1;
    fill_v[3] = 32'h0000_0005; fill_n[3] = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    step();

    // 1: reset then idle
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_Y", 64'(out_Y), 64'd0);
    chk("rst_accepted", 64'(accepted), 64'd0);

    // 2: single push (NOR result of zero) then pop
    push_one(2'b11, 32'h0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_zero", 64'(out_zero), 64'd1);
    chk("single_neg", 64'(out_neg), 64'd0);
    chk("single_op", 64'(out_op), 64'd3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_valid", 64'(out_valid), 64'd0);
    chk("single_pop_count", 64'(count), 64'd0);

    // 3: fill, hold off while full, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) push_one(2'(i), fill_v[i]);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_Y     = 32'h9;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    chk("full_hold_accepted", 64'(accepted), 64'd4);
    chk("full_hold_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_Y", 64'(out_Y), 64'(fill_v[i]));
      chk("drain_neg", 64'(out_neg), 64'(fill_n[i]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid), 64'd0);

    // 4: full with push and pop requested together: pop only
    for (int i = 0; i < 4; i++) push_one(2'b01, 32'h10 + 32'(i));
    chk("full2_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b1;
    in_Y      = 32'h77;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_in_ready", 64'(in_ready), 64'd1);
    chk("full_pop_accepted", 64'(accepted), 64'd8);
    chk("full_pop_head", 64'(out_Y), 64'h11);

    // 5: streaming at occupancy 2
    do_reset();
    push_one(2'b10, 32'hA0);
    push_one(2'b10, 32'hA1);
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_op     = 2'(i);
      in_Y      = 32'd100 + 32'(i);
      chk("stream_Y", 64'(out_Y), (i < 2) ? 64'hA0 + 64'(i) : 64'd100 + 64'(i - 2));
      step();
      chk("stream_count", 64'(count), 64'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_accepted", 64'(accepted), 64'd22);

    // 6a: asynchronous reset mid-cycle with three entries held
    do_reset();
    for (int i = 0; i < 3; i++) push_one(2'b00, 32'h20 + 32'(i));
    chk("pre_areset_count", 64'(count), 64'd3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_out_Y", 64'(out_Y), 64'd0);
    #1;
    reset = 1'b0;
    step();
    chk("post_areset_count", 64'(count), 64'd0);
    chk("post_areset_ready", 64'(in_ready), 64'd1);

    // 6b: 65536 pushes wrap the accepted counter
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_Y = 32'(i);
      step();
    end
    chk("acc_ffff", 64'(accepted), 64'hFFFF);
    step();
    chk("acc_wrap", 64'(accepted), 64'h0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
